// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: md_op encodings,
// FSM state encoding, latency constants and operation-class helpers.
// Optional feature macro: MDU_MADD_EN (adds MADD/MSUB to the multiply class).
package mdu_hilo_pkg;

    // md_op encodings as presented by ID/EX
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    // FSM states of the unit
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    // Latencies: divide is 32 restoring iterations plus one sign-fixup cycle
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 33;

    // LO value written on any divide by zero
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Operations that occupy the multiplier path
    function automatic logic is_mul_op(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MSUB);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    // Operations that occupy the iterative divider
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_div_iter.sv
// Restoring unsigned divider core, one quotient bit per cycle.
// load starts a new division; the core then iterates ITERS times on its own.
// done is high during the final iteration cycle, so quotient/remainder are
// final right after the edge on which done was seen high.
module mdu_div_iter #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam int CW = $clog2(ITERS + 1);

    logic [CW-1:0] count;
    logic [31:0]   dvs;
    logic [32:0]   shifted;
    logic [32:0]   diff;

    // Partial remainder shifted left with the next dividend bit, then trial subtract
    assign shifted = {remainder, quotient[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign done    = (count == CW'(1));

    // Iteration registers: quotient shifts in from the dividend, remainder restores on borrow
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
        end else if (load) begin
            count     <= CW'(ITERS);
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (count != '0) begin
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Handshake: an op is taken when start=1, flush=0 and the unit is idle;
// while busy=1 any start is ignored and stall stays high so the pipeline
// re-presents the op; HI/LO change only on the edge where busy drops (or
// on the accept edge of MTHI/MTLO), and never on an edge with flush high.
// Optional feature macro: MDU_MADD_EN enables MADD/MSUB accumulation.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e         state;
    logic [2:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [CNT_W-1:0] cnt;

    logic           accept;
    logic           div_load;
    logic [31:0]    div_a_mag;
    logic [31:0]    div_b_mag;
    logic [31:0]    div_quo;
    logic [31:0]    div_rem;
    logic           div_done;

    logic           mul_signed;
    logic [63:0]    a_ext;
    logic [63:0]    b_ext;
    logic [63:0]    prod;
    logic [63:0]    mul_res;

    logic           neg_q;
    logic           neg_r;
    logic [63:0]    div_res;

    // Stall covers the in-flight op and a long op arriving this cycle
    assign stall  = busy | (start & (is_mul_op(md_op) | is_div_op(md_op)) & ~flush);
    assign accept = start & ~flush & (state == S_IDLE);

    // Divider works on magnitudes; signs are restored in FIX
    assign div_load  = accept & is_div_op(md_op);
    assign div_a_mag = ((md_op == OP_DIV) && A[31]) ? (~A + 32'd1) : A;
    assign div_b_mag = ((md_op == OP_DIV) && B[31]) ? (~B + 32'd1) : B;

    mdu_div_iter #(
        .ITERS(DIV_CYCLES - 1)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .dividend (div_a_mag),
        .divisor  (div_b_mag),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    // Low 64 bits of the product of extended operands give the signed or unsigned result
    assign mul_signed = (op_q != OP_MULTU);
    assign a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod       = a_ext * b_ext;

    // Final multiply value, optionally accumulated into the current HI/LO
    always_comb begin
        mul_res = prod;
`ifdef MDU_MADD_EN
        if (op_q == OP_MADD) begin
            mul_res = {hi, lo} + prod;
        end else if (op_q == OP_MSUB) begin
            mul_res = {hi, lo} - prod;
        end
`endif
    end

    // Sign fixup: quotient truncates toward zero, remainder follows the dividend
    assign neg_q = (op_q == OP_DIV) & (a_q[31] ^ b_q[31]);
    assign neg_r = (op_q == OP_DIV) & a_q[31];

    // Divide result as {HI, LO}; zero divisor returns the dividend and all-ones
    always_comb begin
        div_res = {(neg_r ? (~div_rem + 32'd1) : div_rem),
                   (neg_q ? (~div_quo + 32'd1) : div_quo)};
        if (b_q == 32'd0) begin
            div_res = {a_q, DIV0_LO};
        end
    end

    // Control FSM with HI/LO write-back; flush and reset abandon without writing
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (md_op == OP_MTHI) begin
                            hi <= A;
                        end else if (md_op == OP_MTLO) begin
                            lo <= A;
                        end else if (is_mul_op(md_op)) begin
                            op_q  <= md_op;
                            a_q   <= A;
                            b_q   <= B;
                            cnt   <= CNT_W'(MUL_CYCLES - 1);
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else if (is_div_op(md_op)) begin
                            op_q  <= md_op;
                            a_q   <= A;
                            b_q   <= B;
                            busy  <= 1'b1;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= mul_res;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    {hi, lo} <= div_res;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
